// File: rtl/tx_sched.sv
// tx_sched: byte scheduler in front of the UART TX escape stage.
//
// Shares the single TX byte path between the TAP data requester (multi-byte
// bursts) and the command requester (single command bytes). A byte is
// accepted only in IDLE while the escape stage reports ready. The write pulse
// follows one cycle later. A HOLD window of HOLDOFF cycles follows each
// pulse, during which TX_READY_I is ignored because the escape stage's
// registered ready has not yet caught up with the write.
// Commands win at burst boundaries. An open data burst (burst lock) blocks
// commands until its last byte is accepted.
//
// Optional feature macro: TX_SCHED_FAIR_EN. When defined, a saturating streak
// counter forces a pending data byte through after MAX_CMD_STREAK
// back-to-back command accepts.
//
// Parameters:
//   MAX_CMD_STREAK  commands accepted while data is pending before data is forced (>=1)
//   HOLDOFF         cycles after a write pulse during which TX_READY_I is ignored (>=1)
//
// Ports:
//   CLK_I, RST_I                          clock, asynchronous active-high reset
//   DATA_VALID_I, DATA_I, DATA_LAST_I     data requester
//   DATA_READY_O                          data accepted this cycle (combinational)
//   CMD_VALID_I, CMD_I                    command requester
//   CMD_READY_O                           command accepted this cycle (combinational)
//   TX_READY_I                            escape stage registered ready
//   WRITE_O, DATA_SEND_O                  data write pulse and byte
//   WRITE_COMMAND_O, COMMAND_O            command write pulse and byte
//   BUSY_O                                not IDLE, or a burst lock is held
module tx_sched #(
  parameter int MAX_CMD_STREAK = 4,
  parameter int HOLDOFF        = 2
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       DATA_VALID_I,
  input  logic [7:0] DATA_I,
  input  logic       DATA_LAST_I,
  output logic       DATA_READY_O,
  input  logic       CMD_VALID_I,
  input  logic [7:0] CMD_I,
  output logic       CMD_READY_O,
  input  logic       TX_READY_I,
  output logic       WRITE_O,
  output logic [7:0] DATA_SEND_O,
  output logic       WRITE_COMMAND_O,
  output logic [7:0] COMMAND_O,
  output logic       BUSY_O
);

  localparam int CW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        lock_q, lock_d;
  logic        write_q, write_d;
  logic        write_cmd_q, write_cmd_d;
  logic [7:0]  data_send_q, data_send_d;
  logic [7:0]  command_q, command_d;

  logic        accept_ok_s;
  logic        force_data_s;
  logic        cmd_ready_s;
  logic        data_ready_s;

  // Readies are gated by RST_I so nothing handshakes while reset is held.
  assign accept_ok_s  = (state_q == IDLE) & TX_READY_I & ~RST_I;
  assign cmd_ready_s  = accept_ok_s & CMD_VALID_I & ~lock_q & ~force_data_s;
  assign data_ready_s = accept_ok_s & DATA_VALID_I & (lock_q | force_data_s | ~CMD_VALID_I);

  assign DATA_READY_O    = data_ready_s;
  assign CMD_READY_O     = cmd_ready_s;
  assign WRITE_O         = write_q;
  assign WRITE_COMMAND_O = write_cmd_q;
  assign DATA_SEND_O     = data_send_q;
  assign COMMAND_O       = command_q;
  assign BUSY_O          = (state_q != IDLE) | lock_q;

`ifdef TX_SCHED_FAIR_EN
  localparam int SW = $clog2(MAX_CMD_STREAK + 1);

  logic [SW-1:0] streak_q, streak_d;

  assign force_data_s = (streak_q == SW'(MAX_CMD_STREAK));

  // Streak of command accepts made while data was waiting; saturates at the limit.
  always_comb begin
    streak_d = streak_q;
    if (data_ready_s) begin
      streak_d = '0;
    end else if (cmd_ready_s && DATA_VALID_I && (streak_q != SW'(MAX_CMD_STREAK))) begin
      streak_d = streak_q + 1'b1;
    end else begin
      streak_d = streak_q;
    end
  end

  // Streak counter register.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign force_data_s = 1'b0;
`endif

  // Next-state, burst lock and output-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_d      = lock_q;
    write_d     = 1'b0;
    write_cmd_d = 1'b0;
    data_send_d = data_send_q;
    command_d   = command_q;
    case (state_q)
      IDLE: begin
        if (data_ready_s) begin
          data_send_d = DATA_I;
          write_d     = 1'b1;
          lock_d      = ~DATA_LAST_I;
          state_d     = ISSUE;
        end else if (cmd_ready_s) begin
          command_d   = CMD_I;
          write_cmd_d = 1'b1;
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = HOLD;
        cnt_d   = CW'(HOLDOFF);
      end
      HOLD: begin
        // The count still reads 1 in the last HOLD cycle; leave on that cycle.
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lock_q      <= 1'b0;
      write_q     <= 1'b0;
      write_cmd_q <= 1'b0;
      data_send_q <= 8'h00;
      command_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_q      <= lock_d;
      write_q     <= write_d;
      write_cmd_q <= write_cmd_d;
      data_send_q <= data_send_d;
      command_q   <= command_d;
    end
  end

endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: self-checking bench for tx_sched.
// A timestamp-based reference model predicts readies, pulses, held bytes and
// BUSY_O every cycle. Directed scenarios pin the model with literal
// expectations, and a randomized phase stresses the arbitration.
// Define TX_SCHED_FAIR_EN for both the bench and the RTL to check the fairness build.
module tb_tx_sched;

  localparam int MAXS = 4;
  localparam int HOLD = 2;
`ifdef TX_SCHED_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       RST_I = 1'b1;
  logic       DATA_VALID_I = 1'b0;
  logic [7:0] DATA_I = 8'h00;
  logic       DATA_LAST_I = 1'b0;
  logic       DATA_READY_O;
  logic       CMD_VALID_I = 1'b0;
  logic [7:0] CMD_I = 8'h00;
  logic       CMD_READY_O;
  logic       TX_READY_I = 1'b1;
  logic       WRITE_O;
  logic [7:0] DATA_SEND_O;
  logic       WRITE_COMMAND_O;
  logic [7:0] COMMAND_O;
  logic       BUSY_O;

  int checks = 0;
  int errors = 0;

  tx_sched #(.MAX_CMD_STREAK(MAXS), .HOLDOFF(HOLD)) dut (
    .CLK_I(clk), .RST_I(RST_I),
    .DATA_VALID_I(DATA_VALID_I), .DATA_I(DATA_I), .DATA_LAST_I(DATA_LAST_I),
    .DATA_READY_O(DATA_READY_O),
    .CMD_VALID_I(CMD_VALID_I), .CMD_I(CMD_I), .CMD_READY_O(CMD_READY_O),
    .TX_READY_I(TX_READY_I),
    .WRITE_O(WRITE_O), .DATA_SEND_O(DATA_SEND_O),
    .WRITE_COMMAND_O(WRITE_COMMAND_O), .COMMAND_O(COMMAND_O),
    .BUSY_O(BUSY_O)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse log: {is_cmd, byte} and the cycle of each pulse.
  logic [8:0] plog[$];
  int         pcyc[$];

  // Reference model: a byte accepted at cycle t blocks accepts until t+2+HOLD.
  int         cyc = 0;
  int         m_next_ok = 0;
  bit         m_lock = 1'b0;
  int         m_streak = 0;
  bit         m_pw = 1'b0, m_pc = 1'b0;
  logic [7:0] m_ds = 8'h00, m_cm = 8'h00;

  always @(negedge clk) begin
    bit idle, frc, ecr, edr;
    if (RST_I) begin
      chk("rst_data_ready", DATA_READY_O, 0);
      chk("rst_cmd_ready", CMD_READY_O, 0);
      chk("rst_write", WRITE_O, 0);
      chk("rst_write_cmd", WRITE_COMMAND_O, 0);
      chk("rst_data_send", DATA_SEND_O, 0);
      chk("rst_command", COMMAND_O, 0);
      chk("rst_busy", BUSY_O, 0);
      m_next_ok = 0; m_lock = 1'b0; m_streak = 0;
      m_pw = 1'b0; m_pc = 1'b0; m_ds = 8'h00; m_cm = 8'h00;
    end else begin
      idle = (cyc >= m_next_ok);
      frc  = FAIR && (m_streak == MAXS);
      ecr  = idle && TX_READY_I && CMD_VALID_I && !m_lock && !frc;
      edr  = idle && TX_READY_I && DATA_VALID_I && (m_lock || frc || !CMD_VALID_I);
      chk("data_ready", DATA_READY_O, edr);
      chk("cmd_ready", CMD_READY_O, ecr);
      chk("write", WRITE_O, m_pw);
      chk("write_cmd", WRITE_COMMAND_O, m_pc);
      chk("data_send", DATA_SEND_O, m_ds);
      chk("command", COMMAND_O, m_cm);
      chk("busy", BUSY_O, !idle || m_lock);
      if (WRITE_O) begin plog.push_back({1'b0, DATA_SEND_O}); pcyc.push_back(cyc); end
      if (WRITE_COMMAND_O) begin plog.push_back({1'b1, COMMAND_O}); pcyc.push_back(cyc); end
      m_pw = edr;
      m_pc = ecr;
      if (edr) begin
        m_ds = DATA_I;
        m_lock = !DATA_LAST_I;
        m_streak = 0;
        m_next_ok = cyc + 2 + HOLD;
      end
      if (ecr) begin
        m_cm = CMD_I;
        if (DATA_VALID_I && m_streak < MAXS) m_streak++;
        m_next_ok = cyc + 2 + HOLD;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    DATA_VALID_I = 1'b0; CMD_VALID_I = 1'b0; TX_READY_I = 1'b1;
    RST_I = 1'b1;
    tick(); tick();
    RST_I = 1'b0;
    tick();
  endtask

  task automatic send_data(input logic [7:0] b, input logic last);
    bit ok = 1'b0;
    DATA_I = b; DATA_LAST_I = last; DATA_VALID_I = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (DATA_READY_O) ok = 1'b1;
      @(posedge clk); #1;
    end
    DATA_VALID_I = 1'b0;
    chk("data_accept_bound", ok, 1);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    bit ok = 1'b0;
    CMD_I = b; CMD_VALID_I = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (CMD_READY_O) ok = 1'b1;
      @(posedge clk); #1;
    end
    CMD_VALID_I = 1'b0;
    chk("cmd_accept_bound", ok, 1);
  endtask

  initial begin
    int n;
    logic [8:0] exp_seq[7];
    bit dacc, cacc;
    int burst_rem;

    // Reset values.
    @(negedge clk);
    chk("reset_write_lit", WRITE_O, 0);
    chk("reset_data_send_lit", DATA_SEND_O, 0);
    chk("reset_busy_lit", BUSY_O, 0);
    @(posedge clk); #1;
    RST_I = 1'b0;
    tick();

    // Single byte: pulse one cycle after accept, next accept four cycles later.
    n = plog.size();
    send_data(8'h41, 1'b1);
    @(negedge clk);
    chk("single_write_lit", WRITE_O, 1);
    chk("single_byte_lit", DATA_SEND_O, 8'h41);
    @(posedge clk); #1;
    send_data(8'h42, 1'b1);
    tick(); tick();
    chk("single_count", plog.size() - n, 2);
    if (plog.size() - n == 2) chk("byte_period", pcyc[n+1] - pcyc[n], 4);

    // Burst holds off a command raised after its first byte.
    do_reset();
    n = plog.size();
    send_data(8'h10, 1'b0);
    fork
      begin send_data(8'h11, 1'b0); send_data(8'h12, 1'b1); end
      send_cmd(8'hA5);
    join
    repeat (5) tick();
    chk("burst_count", plog.size() - n, 4);
    if (plog.size() - n == 4) begin
      chk("burst_0", plog[n],   9'h010);
      chk("burst_1", plog[n+1], 9'h011);
      chk("burst_2", plog[n+2], 9'h012);
      chk("burst_cmd", plog[n+3], 9'h1A5);
    end

    // Simultaneous requests: command first.
    do_reset();
    n = plog.size();
    fork
      send_cmd(8'h3C);
      send_data(8'h77, 1'b1);
    join
    repeat (5) tick();
    chk("simul_count", plog.size() - n, 2);
    if (plog.size() - n == 2) begin
      chk("simul_first", plog[n], 9'h13C);
      chk("simul_second", plog[n+1], 9'h077);
    end

    // Six commands against one pending data byte.
    do_reset();
    n = plog.size();
    fork
      for (int i = 0; i < 6; i++) send_cmd(8'hC0 + 8'(i));
      send_data(8'h55, 1'b1);
    join
    repeat (6) tick();
`ifdef TX_SCHED_FAIR_EN
    exp_seq = '{9'h1C0, 9'h1C1, 9'h1C2, 9'h1C3, 9'h055, 9'h1C4, 9'h1C5};
`else
    exp_seq = '{9'h1C0, 9'h1C1, 9'h1C2, 9'h1C3, 9'h1C4, 9'h1C5, 9'h055};
`endif
    chk("streak_count", plog.size() - n, 7);
    if (plog.size() - n == 7)
      for (int i = 0; i < 7; i++) chk($sformatf("streak_%0d", i), plog[n+i], exp_seq[i]);

    // Escape stage busy for 10 cycles after an ESC byte.
    do_reset();
    n = plog.size();
    send_data(8'hB1, 1'b1);
    TX_READY_I = 1'b0;
    fork
      send_data(8'h22, 1'b1);
      begin repeat (10) tick(); TX_READY_I = 1'b1; end
    join
    repeat (3) tick();
    chk("esc_count", plog.size() - n, 2);
    if (plog.size() - n == 2) begin
      chk("esc_first", plog[n], 9'h0B1);
      chk("esc_second", plog[n+1], 9'h022);
      chk("esc_gap", pcyc[n+1] - pcyc[n], 11);
    end

    // Reset during ISSUE drops the pulse and the burst lock.
    do_reset();
    n = plog.size();
    send_data(8'h33, 1'b0);
    RST_I = 1'b1;
    @(negedge clk);
    chk("rst_issue_write_lit", WRITE_O, 0);
    chk("rst_issue_busy_lit", BUSY_O, 0);
    @(posedge clk); #1;
    tick();
    RST_I = 1'b0;
    tick();
    fork
      send_cmd(8'h99);
      send_data(8'h44, 1'b1);
    join
    repeat (5) tick();
    chk("rst_issue_count", plog.size() - n, 2);
    if (plog.size() - n == 2) begin
      chk("rst_issue_first", plog[n], 9'h199);
      chk("rst_issue_second", plog[n+1], 9'h044);
    end

    // Randomized traffic checked cycle by cycle against the model.
    do_reset();
    burst_rem = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      dacc = DATA_READY_O;
      cacc = CMD_READY_O;
      @(posedge clk); #1;
      if (dacc) begin DATA_VALID_I = 1'b0; burst_rem--; end
      if (cacc) CMD_VALID_I = 1'b0;
      if (!DATA_VALID_I && ($urandom % 3 == 0)) begin
        if (burst_rem <= 0) burst_rem = 1 + int'($urandom_range(0, 3));
        DATA_VALID_I = 1'b1;
        DATA_I = 8'($urandom);
        DATA_LAST_I = (burst_rem == 1);
      end
      if (!CMD_VALID_I && ($urandom % 4 == 0)) begin
        CMD_VALID_I = 1'b1;
        CMD_I = 8'($urandom);
      end
      TX_READY_I = ($urandom % 4 != 0);
      RST_I = ($urandom % 500 == 0);
    end
    RST_I = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
